// File: rtl/gpu_write_sequencer.sv
// Command queue in front of the shared GPU/VRAM write port. Pixel and ascii
// commands become single writes; fill sweeps the whole frame in raster order.
module gpu_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  // cmd: a beat transfers at a rising edge with cmd_valid && cmd_ready;
  // cmd_ready is !full and never looks at cmd_valid or the pop side.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [19:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        scan_busy,
  output logic [19:0] gpu_address,
  output logic        gpu_mode,
  output logic [7:0]  gpu_data,
  output logic        vram_we,
  output logic        busy,
  output logic        fill_done,
  output logic        cmd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);
  localparam logic [9:0]    X_LAST  = 10'(H_PIXELS - 1);
  localparam logic [9:0]    Y_LAST  = 10'(V_PIXELS - 1);
  localparam logic [1:0]    OP_PIX  = 2'b00;
  localparam logic [1:0]    OP_ASC  = 2'b01;
  localparam logic [1:0]    OP_FILL = 2'b10;

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t          state, state_n;
  logic [29:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_n;
  logic [9:0]      x, y, x_n, y_n;
  logic [7:0]      colour, colour_n;
  logic [19:0]     addr_n;
  logic [7:0]      data_n;
  logic            mode_n, we_n, done_n, err_n;
  logic            push, pop, at_end;
  logic [1:0]      head_op;
  logic [19:0]     head_addr;
  logic [7:0]      head_data;

  assign cmd_ready = (count != DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0) && !scan_busy;
  assign head_op   = mem[rd_ptr][29:28];
  assign head_addr = mem[rd_ptr][27:8];
  assign head_data = mem[rd_ptr][7:0];
  assign at_end    = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
  end

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + ONE_C;
    else if (!push && pop) count_n = count - ONE_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_P;
      if (pop)  rd_ptr <= rd_ptr + ONE_P;
      count <= count_n;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pop && head_op == OP_FILL) state_n = S_FILL;
      S_FILL:  if (!scan_busy && at_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered write port and counters
  always_comb begin
    we_n     = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    addr_n   = gpu_address;
    mode_n   = gpu_mode;
    data_n   = gpu_data;
    x_n      = x;
    y_n      = y;
    colour_n = colour;
    case (state)
      S_IDLE: begin
        if (pop) begin
          case (head_op)
            OP_PIX, OP_ASC: begin
              we_n   = 1'b1;
              mode_n = (head_op == OP_PIX);
              addr_n = head_addr;
              data_n = head_data;
            end
            OP_FILL: begin
              colour_n = head_data;
              x_n      = '0;
              y_n      = '0;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      S_FILL: begin
        // scan_busy freezes the sweep so every pixel is written exactly once
        if (!scan_busy) begin
          we_n   = 1'b1;
          mode_n = 1'b1;
          addr_n = {y, x};
          data_n = colour;
          done_n = at_end;
          if (x == X_LAST) begin
            x_n = '0;
            y_n = y + 10'd1;
          end else begin
            x_n = x + 10'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_we     <= 1'b0;
      gpu_address <= '0;
      gpu_mode    <= 1'b0;
      gpu_data    <= '0;
      fill_done   <= 1'b0;
      cmd_err     <= 1'b0;
      busy        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
    end else begin
      vram_we     <= we_n;
      gpu_address <= addr_n;
      gpu_mode    <= mode_n;
      gpu_data    <= data_n;
      fill_done   <= done_n;
      cmd_err     <= err_n;
      busy        <= (state_n != S_IDLE) || (count_n != '0);
      x           <= x_n;
      y           <= y_n;
      colour      <= colour_n;
    end
  end

endmodule

// File: tb/tb_gpu_write_sequencer.sv
// Directed plus randomized bench for gpu_write_sequencer on a 4x2 frame;
// expected writes come from a command-level model kept in a queue.
module tb_gpu_write_sequencer;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [19:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        scan_busy;
  logic [19:0] gpu_address;
  logic        gpu_mode;
  logic [7:0]  gpu_data;
  logic        vram_we, busy, fill_done, cmd_err;

  int total = 0, passed = 0;
  logic [29:0] exp_q[$];   // {done, mode, addr[19:0], data[7:0]}
  logic [29:0] mon_e;
  int exp_err = 0, err_seen = 0, wr_seen = 0, done_seen = 0, cyc = 0;
  int wr_log[$];
  logic sb_last = 1'b0;
  int sb_mode = 0;         // 0 hold, 1 random, 2 toggle

  gpu_write_sequencer #(.FIFO_DEPTH(D), .H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .scan_busy(scan_busy),
    .gpu_address(gpu_address), .gpu_mode(gpu_mode), .gpu_data(gpu_data),
    .vram_we(vram_we), .busy(busy), .fill_done(fill_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Reference model: what writes a command must eventually produce.
  task automatic model_cmd(input logic [1:0] op, input logic [19:0] a, input logic [7:0] d);
    logic [9:0] xx, yy;
    logic last;
    case (op)
      2'b00: exp_q.push_back({1'b0, 1'b1, a, d});
      2'b01: exp_q.push_back({1'b0, 1'b0, a, d});
      2'b10: begin
        for (int yi = 0; yi < V; yi++) begin
          for (int xi = 0; xi < H; xi++) begin
            xx = 10'(xi);
            yy = 10'(yi);
            last = (yi == V - 1) && (xi == H - 1);
            exp_q.push_back({last, 1'b1, yy, xx, d});
          end
        end
      end
      default: exp_err++;
    endcase
  endtask

  always @(posedge clk) begin
    sb_last <= scan_busy;
    cyc <= cyc + 1;
  end

  // Scoreboard: every observed write must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vram_we) begin
        wr_seen++;
        wr_log.push_back(cyc);
        check("we_while_scan", 32'(sb_last), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {12'b0, gpu_address}, 32'hFFFFFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {12'b0, gpu_address}, {12'b0, mon_e[27:8]});
          check("wr_mode", 32'(gpu_mode), 32'(mon_e[28]));
          check("wr_data", {24'b0, gpu_data}, {24'b0, mon_e[7:0]});
          check("wr_done", 32'(fill_done), 32'(mon_e[29]));
        end
      end else if (fill_done) begin
        check("done_without_we", 1, 0);
      end
      if (fill_done) done_seen++;
      if (cmd_err) begin
        err_seen++;
        check("err_with_we", 32'(vram_we), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (sb_mode == 1)      scan_busy = ($urandom_range(0, 3) == 0);
    else if (sb_mode == 2) scan_busy = ~scan_busy;
  endtask

  task automatic send(input logic [1:0] op, input logic [19:0] a, input logic [7:0] d);
    logic acc;
    int n;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      acc = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (acc) model_cmd(op, a, d);
    else check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 1);
    step();
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(vram_we), 0);
    check({tag, "_addr"},  {12'b0, gpu_address}, 0);
    check({tag, "_mode"},  32'(gpu_mode), 0);
    check({tag, "_data"},  {24'b0, gpu_data}, 0);
    check({tag, "_done"},  32'(fill_done), 0);
    check({tag, "_err"},   32'(cmd_err), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    int w0, k, n, d0;
    logic [1:0] rop;
    int r;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
    scan_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // T1: pixel write latency and single strobe
    send(2'b00, 20'h0A005, 8'h3C);
    @(negedge clk); check("t1_early", 32'(vram_we), 0);
    @(negedge clk); check("t1_latency", 32'(vram_we), 1);
    @(negedge clk); check("t1_single", 32'(vram_we), 0);
    check("t1_hold_addr", {12'b0, gpu_address}, 32'h0A005);

    // T2: ascii write
    w0 = wr_seen;
    send(2'b01, 20'h00010, 8'h41);
    drain();
    check("t2_count", wr_seen - w0, 1);
    check("t2_mode_hold", 32'(gpu_mode), 0);

    // T3: writes held off by scan_busy, then back-to-back
    w0 = wr_seen;
    k = wr_log.size();
    scan_busy = 1'b1;
    send(2'b00, 20'h00020, 8'h11);
    send(2'b00, 20'h00021, 8'h22);
    repeat (10) step();
    check("t3_held", wr_seen - w0, 0);
    scan_busy = 1'b0;
    drain();
    check("t3_count", wr_seen - w0, 2);
    if (wr_log.size() >= k + 2) check("t3_consecutive", wr_log[k+1] - wr_log[k], 1);
    else check("t3_log", wr_log.size(), k + 2);

    // T4: fill the queue, fifth command stalls at the source
    w0 = wr_seen;
    scan_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(2'b00, 20'h00100 + 20'(i), 8'h50 + 8'(i));
    check("t4_ready_full", 32'(cmd_ready), 0);
    check("t4_busy", 32'(busy), 1);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_addr = 20'h00104;
    cmd_data = 8'h54;
    repeat (3) begin
      check("t4_full", 32'(cmd_ready), 0);
      step();
    end
    scan_busy = 1'b0;
    send(2'b00, 20'h00104, 8'h54);
    drain();
    check("t4_count", wr_seen - w0, 5);

    // T5: fill then a queued pixel, first free-running then with scan_busy toggling
    for (int pass = 0; pass < 2; pass++) begin
      w0 = wr_seen;
      d0 = done_seen;
      sb_mode = pass * 2;
      send(2'b10, 20'h00000, 8'hE0);
      send(2'b00, 20'h00001, 8'h07);
      drain();
      sb_mode = 0;
      scan_busy = 1'b0;
      step();
      check("t5_count", wr_seen - w0, 9);
      check("t5_done_pulses", done_seen - d0, 1);
    end

    // T6: reserved op, then reset in the middle of a fill
    w0 = wr_seen;
    send(2'b11, 20'h12345, 8'hAA);
    drain();
    check("t6_err", err_seen, exp_err);
    check("t6_no_write", wr_seen - w0, 0);
    w0 = wr_seen;
    d0 = done_seen;
    send(2'b10, 20'h00000, 8'h99);
    send(2'b00, 20'h00003, 8'h01);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (wr_seen - w0 < 3 && n < 100);
    check("t6_reach_write3", wr_seen - w0, 3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    check("t6_aborted", wr_seen - w0, 3);
    check("t6_no_done", done_seen - d0, 0);

    // Randomized mix against the model
    sb_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      rop = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r == 7) ? 2'b11 : 2'b10;
      send(rop, 20'($urandom_range(0, 20'hFFFFF)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) step();
    end
    sb_mode = 0;
    scan_busy = 1'b0;
    drain();
    check("rand_err", err_seen, exp_err);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
